pattern_pixel_source: RTL

- Consumer side of the pattern data register.
- Accepts pattern bytes written from the internal data bus and buffers them in a 2-entry queue.
- Serves them, one pixel per handshake, to the blitter write path in 8bpp or 4bpp form.
- Flags pixels matching a compare colour so the write path can inhibit them (transparency).

---
 rtl/pattern_pkg.sv | 14 +
 rtl/pattern_pixel_source_if.sv | 27 ++
 rtl/pat_byte_fifo.sv | 63 ++++++
 rtl/pattern_pixel_source.sv | 107 ++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern pixel source.
package pattern_pkg;

  localparam logic RES_8BPP = 1'b0;
  localparam logic RES_4BPP = 1'b1;

  localparam int unsigned PAT_DEPTH = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       res4;
  } pat_entry_t;

endpackage

// File: rtl/pattern_pixel_source_if.sv
// Pattern load / pixel handshake bundle between the data bus, write path and pixel source.
interface pattern_pixel_source_if #(
  parameter int unsigned PIXW = 8
);
  logic            LDPATL;
  logic [7:0]      ID;
  logic            RES4;
  logic            CMPEN;
  logic [7:0]      CMPCOL;
  logic            PIXTAKE;
  logic            CLROVR;
  logic [PIXW-1:0] PIXD;
  logic            PIXVALID;
  logic            INHIB;
  logic            PATFULL;
  logic            OVERRUN;

  modport master (
    output LDPATL, ID, RES4, CMPEN, CMPCOL, PIXTAKE, CLROVR,
    input  PIXD, PIXVALID, INHIB, PATFULL, OVERRUN
  );

  modport slave (
    input  LDPATL, ID, RES4, CMPEN, CMPCOL, PIXTAKE, CLROVR,
    output PIXD, PIXVALID, INHIB, PATFULL, OVERRUN
  );
endinterface

// File: rtl/pat_byte_fifo.sv
// Small synchronous FIFO of pattern entries; exposes the head and the entry behind it
// so the consumer can precompute its next registered outputs.
module pat_byte_fifo
  import pattern_pkg::*;
#(
  parameter int unsigned DEPTH = PAT_DEPTH,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  pat_entry_t      wdata_i,
  input  logic            pop_i,
  output pat_entry_t      head_o,
  output pat_entry_t      next_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  pat_entry_t            mem_q [DEPTH];
  pat_entry_t            mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PtrW'(1)];
  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pattern_pixel_source.sv
// Pattern data consumer: queues loaded bytes and serves 8bpp or 4bpp pixels with a
// transparency flag to the blitter write path.
module pattern_pixel_source
  import pattern_pkg::*;
#(
  parameter int unsigned DEPTH = PAT_DEPTH,
  parameter int unsigned PIXW  = 8
) (
  input  logic                   CLK,
  input  logic                   RESETL,
  pattern_pixel_source_if.slave  pat
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  pat_entry_t      head, head_next, push_entry, nxt_head;
  logic [CntW-1:0] count, cnt_nxt;
  logic            full, empty;
  logic            load, take, retire, push, drop, valid_nxt, match;
  logic [3:0]      nib_val;
  logic [7:0]      byte_val;

  logic            nib_q, nib_d;
  logic [PIXW-1:0] pixd_q, pixd_d;
  logic            pixvalid_q, pixvalid_d;
  logic            inhib_q, inhib_d;
  logic            patfull_q, patfull_d;
  logic            overrun_q, overrun_d;

  pat_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESETL),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (retire),
    .head_o  (head),
    .next_o  (head_next),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    push_entry.data = pat.ID;
    push_entry.res4 = pat.RES4;

    load   = ~pat.LDPATL;
    take   = pat.PIXTAKE & ~empty;
    retire = take & ((head.res4 == RES_8BPP) | nib_q);
    // A retiring take frees a slot in the same edge, so a full queue can still accept.
    push   = load & (~full | retire);
    drop   = load & full & ~retire;

    nib_d = nib_q;
    if (take && head.res4 == RES_4BPP) nib_d = ~nib_q;

    cnt_nxt = count + CntW'(push) - CntW'(retire);

    // Outputs are registered from the head as it will be after this edge.
    nxt_head = head;
    if (retire) begin
      nxt_head = (count > CntW'(1)) ? head_next : push_entry;
    end else if (empty) begin
      nxt_head = push_entry;
    end
    valid_nxt = (cnt_nxt != '0);

    nib_val  = nib_d ? nxt_head.data[7:4] : nxt_head.data[3:0];
    byte_val = (nxt_head.res4 == RES_4BPP) ? {nib_val, nib_val} : nxt_head.data;
    match    = (nxt_head.res4 == RES_4BPP) ? (nib_val == pat.CMPCOL[3:0])
                                           : (nxt_head.data == pat.CMPCOL);

    pixvalid_d = valid_nxt;
    pixd_d     = valid_nxt ? PIXW'(byte_val) : '0;
    inhib_d    = pat.CMPEN & valid_nxt & match;
    patfull_d  = (cnt_nxt == CntW'(DEPTH));
    overrun_d  = drop | (overrun_q & ~pat.CLROVR);
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      nib_q      <= 1'b0;
      pixd_q     <= '0;
      pixvalid_q <= 1'b0;
      inhib_q    <= 1'b0;
      patfull_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      nib_q      <= nib_d;
      pixd_q     <= pixd_d;
      pixvalid_q <= pixvalid_d;
      inhib_q    <= inhib_d;
      patfull_q  <= patfull_d;
      overrun_q  <= overrun_d;
    end
  end

  assign pat.PIXD     = pixd_q;
  assign pat.PIXVALID = pixvalid_q;
  assign pat.INHIB    = inhib_q;
  assign pat.PATFULL  = patfull_q;
  assign pat.OVERRUN  = overrun_q;

endmodule
